// File: rtl/tick_timer_scheduler.sv
// One prescaled one-shot tick timer shared round-robin between N_CH requesters.
// The granted channel owns the timer for dur ticks, then receives a one-cycle done pulse.
module tick_timer_scheduler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*CNT_W-1:0] dur,
  output logic [N_CH-1:0]       gnt,
  output logic [N_CH-1:0]       done,
  output logic                  busy,
  output logic                  tick,
  output logic [CNT_W-1:0]      remaining
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int LW  = (N_CH >= 2) ? $clog2(N_CH) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("tick_timer_scheduler: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (N_CH < 2 || N_CH > 8) begin : g_bad_nch
    $error("tick_timer_scheduler: N_CH must be in 2..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [N_CH-1:0]  gnt_q, done_q;
  logic             busy_q;
  logic [CNT_W-1:0] rem_q;
  logic [PW-1:0]    presc_q;
  logic [LW-1:0]    last_q;

  logic [LW-1:0]    sel_d;
  logic             found_d;
  logic [N_CH-1:0]  onehot_d;
  logic [CNT_W-1:0] dur_sel_d;
  logic             wrap;

  // Round-robin search starting just after the last owner.
  always_comb begin
    int idx;
    idx     = 0;
    sel_d   = '0;
    found_d = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_q) + k) % N_CH;
      if (!found_d && req[idx]) begin
        found_d = 1'b1;
        sel_d   = LW'(idx);
      end
    end
    onehot_d  = N_CH'(1) << sel_d;
    dur_sel_d = dur[int'(sel_d)*CNT_W +: CNT_W];
  end

  assign wrap = (presc_q == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      presc_q <= '0;
      last_q  <= LW'(N_CH - 1);
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            gnt_q   <= onehot_d;
            last_q  <= sel_d;
            busy_q  <= 1'b1;
            presc_q <= '0;
            if (dur_sel_d == '0) begin
              state_q <= S_DONE;
              done_q  <= onehot_d;
              rem_q   <= '0;
            end else begin
              state_q <= S_RUN;
              rem_q   <= dur_sel_d;
            end
          end
        end
        S_RUN: begin
          // Withdrawal wins over expiry; last_q keeps the owner so priority is not lost.
          if (!req[last_q]) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            presc_q <= '0;
          end else if (wrap) begin
            presc_q <= '0;
            if (rem_q == CNT_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= gnt_q;
              rem_q   <= '0;
            end else if (rem_q != '0) begin
              rem_q <= rem_q - CNT_W'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          presc_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          rem_q   <= '0;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = rem_q;
  assign tick      = (state_q == S_RUN) && wrap;
endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed bench for tick_timer_scheduler with DIV=10, N_CH=4, CNT_W=8.
module tb_tick_timer_scheduler;
  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       req;
  logic [N_CH*CNT_W-1:0] dur;
  logic [N_CH-1:0]       gnt, done;
  logic                  busy, tick;
  logic [CNT_W-1:0]      remaining;

  int n_chk = 0;
  int n_err = 0;

  tick_timer_scheduler #(.CLK_HZ(10), .TICK_HZ(1), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .dur(dur), .gnt(gnt), .done(done),
    .busy(busy), .tick(tick), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int ch, input logic [CNT_W-1:0] v);
    dur[ch*CNT_W +: CNT_W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    int order [6];
    logic [N_CH-1:0] exp_g;
    order = '{0, 1, 3, 0, 1, 3};
    req = '0;
    dur = '0;
    reset = 1'b0;
    step(2);
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rem",  32'(remaining), 0);
    chk("rst_tick", 32'(tick), 0);
    reset = 1'b1;

    // Single request, dur=3
    set_dur(0, 8'd3);
    req = 4'b0001;
    step(1);
    chk("s_gnt_G", 32'(gnt), 4'b0001);
    chk("s_rem_G", 32'(remaining), 3);
    chk("s_busy_G", 32'(busy), 1);
    chk("s_tick_G", 32'(tick), 0);
    step(8);
    chk("s_tick_G8", 32'(tick), 0);
    step(1);
    chk("s_tick_G9", 32'(tick), 1);
    chk("s_rem_G9", 32'(remaining), 3);
    step(1);
    chk("s_rem_G10", 32'(remaining), 2);
    chk("s_tick_G10", 32'(tick), 0);
    step(9);
    chk("s_tick_G19", 32'(tick), 1);
    step(1);
    chk("s_rem_G20", 32'(remaining), 1);
    step(9);
    chk("s_tick_G29", 32'(tick), 1);
    chk("s_done_G29", 32'(done), 0);
    step(1);
    chk("s_done_G30", 32'(done), 4'b0001);
    chk("s_gnt_G30", 32'(gnt), 4'b0001);
    chk("s_rem_G30", 32'(remaining), 0);
    chk("s_tick_G30", 32'(tick), 0);
    req = '0;
    step(1);
    chk("s_gnt_G31", 32'(gnt), 0);
    chk("s_done_G31", 32'(done), 0);
    chk("s_busy_G31", 32'(busy), 0);

    // Contention, all durations 1, from reset
    do_reset();
    for (int i = 0; i < N_CH; i++) set_dur(i, 8'd1);
    req = 4'b1011;
    step(1);
    for (int n = 0; n < 6; n++) begin
      exp_g = 4'(1 << order[n]);
      chk($sformatf("c%0d_gnt", n), 32'(gnt), 32'(exp_g));
      chk($sformatf("c%0d_done0", n), 32'(done), 0);
      step(10);
      chk($sformatf("c%0d_done", n), 32'(done), 32'(exp_g));
      step(1);
      chk($sformatf("c%0d_idle", n), 32'(gnt), 0);
      if (n == 5) req = '0;
      step(1);
    end
    chk("c_end_gnt", 32'(gnt), 0);

    // Zero duration on channel 2
    set_dur(2, 8'd0);
    req = 4'b0100;
    step(1);
    chk("z_gnt", 32'(gnt), 4'b0100);
    chk("z_done", 32'(done), 4'b0100);
    chk("z_tick", 32'(tick), 0);
    chk("z_rem", 32'(remaining), 0);
    req = '0;
    step(1);
    chk("z_gnt1", 32'(gnt), 0);
    chk("z_done1", 32'(done), 0);
    chk("z_tick1", 32'(tick), 0);

    // Abort on channel 1 at G+15
    set_dur(1, 8'd5);
    set_dur(0, 8'd1);
    req = 4'b0010;
    step(1);
    chk("a_gnt", 32'(gnt), 4'b0010);
    step(15);
    chk("a_rem15", 32'(remaining), 4);
    req = '0;
    step(1);
    chk("a_gnt16", 32'(gnt), 0);
    chk("a_rem16", 32'(remaining), 0);
    chk("a_done16", 32'(done), 0);
    chk("a_busy16", 32'(busy), 0);
    req = 4'b0011;
    step(1);
    chk("a_next0", 32'(gnt), 4'b0001);
    step(10);
    chk("a_done0", 32'(done), 4'b0001);
    step(2);
    chk("a_next1", 32'(gnt), 4'b0010);
    req = '0;
    step(1);
    chk("a_drop", 32'(gnt), 0);
    chk("a_drop_done", 32'(done), 0);

    // Abort in the expiry tick cycle
    req = 4'b0001;
    step(1);
    chk("x_gnt", 32'(gnt), 4'b0001);
    step(9);
    chk("x_tick9", 32'(tick), 1);
    req = '0;
    step(1);
    chk("x_done10", 32'(done), 0);
    chk("x_gnt10", 32'(gnt), 0);
    chk("x_busy10", 32'(busy), 0);
    step(1);
    chk("x_done11", 32'(done), 0);

    // Reset mid-run
    set_dur(2, 8'd5);
    req = 4'b0100;
    step(1);
    chk("r_gnt", 32'(gnt), 4'b0100);
    step(12);
    reset = 1'b0;
    step(1);
    chk("r_gnt13", 32'(gnt), 0);
    chk("r_done13", 32'(done), 0);
    chk("r_busy13", 32'(busy), 0);
    chk("r_rem13", 32'(remaining), 0);
    chk("r_tick13", 32'(tick), 0);
    reset = 1'b1;
    req = 4'b1111;
    step(1);
    chk("r_first", 32'(gnt), 4'b0001);
    req = '0;
    step(1);
    chk("r_drop", 32'(gnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
